// File: rtl/id_stage.sv
// Decode stage: IF/ID register, 32x32 register file with write-first bypass,
// main decoder, load-use hazard unit and the ID/EX pipeline register.
module id_stage #(
  parameter int CNT_W = 16  // internal stall-counter width, zero-extended onto stall_cnt
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_in,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        PCWrite,
  output logic [8:0]  id_ex_ctrl,
  output logic [31:0] id_ex_rs_data,
  output logic [31:0] id_ex_rt_data,
  output logic [31:0] id_ex_imm,
  output logic [4:0]  id_ex_rs,
  output logic [4:0]  id_ex_rt,
  output logic [4:0]  id_ex_rd,
  output logic [15:0] stall_cnt
);

  typedef struct packed {
    logic [8:0]  ctrl;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } idex_t;

  logic [31:0]      ifid;
  idex_t            ex, ex_nxt;
  logic [31:0]      rf [32];
  logic [8:0]       ctrl;
  logic [31:0]      rs_val, rt_val;
  logic [4:0]       rs_a, rt_a;
  logic             hazard;
  logic [CNT_W-1:0] cnt;

  assign rs_a = ifid[25:21];
  assign rt_a = ifid[20:16];

  // All-zero word is a NOP even though its opcode field looks like R-type.
  always_comb begin
    ctrl = '0;
    if (ifid != '0) begin
      case (ifid[31:26])
        6'h00:   ctrl = 9'h10A;
        6'h23:   ctrl = 9'h1B0;
        6'h2B:   ctrl = 9'h050;
        6'h04:   ctrl = 9'h005;
        6'h08:   ctrl = 9'h110;
        default: ctrl = '0;
      endcase
    end
  end

  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs_a != '0) rs_val = (wb_we && wb_rd == rs_a) ? wb_data : rf[rs_a];
    if (rt_a != '0) rt_val = (wb_we && wb_rd == rt_a) ? wb_data : rf[rt_a];
  end

  // Only registered state feeds the hazard, so PCWrite never sees inst_in.
  assign hazard  = ex.ctrl[7] && (ex.rt != '0) && (ex.rt == rs_a || ex.rt == rt_a);
  assign PCWrite = ~hazard;

  always_comb begin
    ex_nxt.ctrl    = ctrl;
    ex_nxt.rs_data = rs_val;
    ex_nxt.rt_data = rt_val;
    ex_nxt.imm     = {{16{ifid[15]}}, ifid[15:0]};
    ex_nxt.rs      = rs_a;
    ex_nxt.rt      = rt_a;
    ex_nxt.rd      = ifid[15:11];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we && wb_rd != '0) begin
      rf[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid <= '0;
      ex   <= '0;
      cnt  <= '0;
    end else begin
      ex <= hazard ? idex_t'('0) : ex_nxt;
      if (flush)        ifid <= '0;
      else if (!hazard) ifid <= inst_in;
      if (hazard && cnt != '1) cnt <= cnt + CNT_W'(1);
    end
  end

  assign id_ex_ctrl    = ex.ctrl;
  assign id_ex_rs_data = ex.rs_data;
  assign id_ex_rt_data = ex.rt_data;
  assign id_ex_imm     = ex.imm;
  assign id_ex_rs      = ex.rs;
  assign id_ex_rt      = ex.rt;
  assign id_ex_rd      = ex.rd;
  assign stall_cnt     = 16'(cnt);

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: decode vector table, directed hazard/bypass/flush/reset
// sequences, then random traffic against a cycle reference model.
module tb_id_stage;

  typedef struct packed {
    logic [8:0]  ctrl;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } ex_t;

  typedef struct packed {
    logic [31:0] inst;
    ex_t         exp;
  } vec_t;

  localparam logic [31:0] LW   = 32'h8C430004;  // lw   r3,4(r2)
  localparam logic [31:0] ADD  = 32'h00612020;  // add  r4,r3,r1
  localparam logic [31:0] BEQ  = 32'h10220003;  // beq  r1,r2,3
  localparam logic [31:0] ADDI = 32'h20410007;  // addi r1,r2,7

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] inst_in = '0;
  logic        flush = 1'b0, wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;

  logic        pcw, s_pcw;
  logic [8:0]  ctrl, s_ctrl;
  logic [31:0] rsd, rtd, imm, s_rsd, s_rtd, s_imm;
  logic [4:0]  rs, rt, rd, s_rs, s_rt, s_rd;
  logic [15:0] scnt, s_scnt;
  ex_t         dut_ex, sat_ex;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  id_stage u_dut (
    .clk(clk), .rst(rst), .inst_in(inst_in), .flush(flush), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .PCWrite(pcw), .id_ex_ctrl(ctrl),
    .id_ex_rs_data(rsd), .id_ex_rt_data(rtd), .id_ex_imm(imm), .id_ex_rs(rs),
    .id_ex_rt(rt), .id_ex_rd(rd), .stall_cnt(scnt)
  );

  // Narrow counter copy so saturation is reachable in a short run.
  id_stage #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .inst_in(inst_in), .flush(flush), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .PCWrite(s_pcw), .id_ex_ctrl(s_ctrl),
    .id_ex_rs_data(s_rsd), .id_ex_rt_data(s_rtd), .id_ex_imm(s_imm), .id_ex_rs(s_rs),
    .id_ex_rt(s_rt), .id_ex_rd(s_rd), .stall_cnt(s_scnt)
  );

  assign dut_ex = {ctrl, rsd, rtd, imm, rs, rt, rd};
  assign sat_ex = {s_ctrl, s_rsd, s_rtd, s_imm, s_rs, s_rt, s_rd};

  // ---------------- reference model ----------------
  logic [31:0] m_rf [32];
  logic [31:0] m_ifid;
  ex_t         m_ex;
  int          m_cnt;

  function automatic logic [8:0] m_ctrl(logic [31:0] i);
    logic [8:0] RW = 9'h100, MR = 9'h080, MW = 9'h040, MTR = 9'h020;
    logic [8:0] AS = 9'h010, RD = 9'h008, BR = 9'h004;
    if (i == 32'h0) return 9'h0;
    case (i[31:26])
      6'h00:   return RW + RD + 9'd2;
      6'h23:   return RW + MR + MTR + AS;
      6'h2B:   return MW + AS;
      6'h04:   return BR + 9'd1;
      6'h08:   return RW + AS;
      default: return 9'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_we && wb_rd == a) return wb_data;
    return m_rf[a];
  endfunction

  function automatic bit m_haz();
    return m_ex.ctrl[7] && m_ex.rt != 0 &&
           (m_ex.rt == m_ifid[25:21] || m_ex.rt == m_ifid[20:16]);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_ifid = '0;
    m_ex   = '0;
    m_cnt  = 0;
  endtask

  task automatic m_step();
    bit  h = m_haz();
    ex_t n = '0;
    if (!h) n = {m_ctrl(m_ifid), m_read(m_ifid[25:21]), m_read(m_ifid[20:16]),
                 {{16{m_ifid[15]}}, m_ifid[15:0]}, m_ifid[25:21], m_ifid[20:16], m_ifid[15:11]};
    if (wb_we && wb_rd != 0) m_rf[wb_rd] = wb_data;
    if (flush) m_ifid = '0;
    else if (!h) m_ifid = inst_in;
    if (h) m_cnt++;
    m_ex = n;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    m_step();
    #1;
  endtask

  function automatic logic [15:0] sat(int v, int mx);
    return (v > mx) ? 16'(mx) : 16'(v);
  endfunction

  vec_t vt [7];

  initial begin
    vt[0] = {LW,           ex_t'({9'h1B0, 32'h10, 32'h0,  32'h4,        5'd2, 5'd3, 5'd0})};
    vt[1] = {ADD,          ex_t'({9'h10A, 32'h0,  32'h5,  32'h2020,     5'd3, 5'd1, 5'd4})};
    vt[2] = {32'hAC41FFFC, ex_t'({9'h050, 32'h10, 32'h5,  32'hFFFFFFFC, 5'd2, 5'd1, 5'd31})};
    vt[3] = {BEQ,          ex_t'({9'h005, 32'h5,  32'h10, 32'h3,        5'd1, 5'd2, 5'd0})};
    vt[4] = {ADDI,         ex_t'({9'h110, 32'h10, 32'h5,  32'h7,        5'd2, 5'd1, 5'd0})};
    vt[5] = {32'hFC228000, ex_t'({9'h000, 32'h5,  32'h10, 32'hFFFF8000, 5'd1, 5'd2, 5'd16})};
    vt[6] = {32'h00000000, ex_t'('0)};

    m_reset();
    #12;
    chk("reset_ex", dut_ex, 0);
    chk("reset_cnt", scnt, 0);
    chk("reset_pcw", pcw, 1);
    rst = 1'b0;

    // preload r2=0x10, r1=5, r5=0x55
    wb_we = 1; wb_rd = 2; wb_data = 32'h10; cyc();
    wb_rd = 1; wb_data = 32'h5;  cyc();
    wb_rd = 5; wb_data = 32'h55; cyc();
    wb_we = 0;

    foreach (vt[i]) begin
      inst_in = vt[i].inst; cyc();
      inst_in = '0;         cyc();
      chk($sformatf("decode%0d", i), dut_ex, vt[i].exp);
    end

    // load-use
    inst_in = LW;  cyc();
    inst_in = ADD; cyc();
    chk("lu_pcw_low", pcw, 0);
    inst_in = '0;  cyc();
    chk("lu_bubble", ctrl, 0);
    chk("lu_cnt", scnt, 1);
    chk("lu_pcw_high", pcw, 1);
    cyc();
    chk("lu_add_issue", {ctrl, rs, rt, rd}, {9'h10A, 5'd3, 5'd1, 5'd4});

    // bypass and r0
    inst_in = 32'h00E04020; cyc();
    wb_we = 1; wb_rd = 7; wb_data = 32'hDEADBEEF; inst_in = '0; cyc();
    chk("byp_same_cycle", rsd, 32'hDEADBEEF);
    wb_we = 0; inst_in = 32'h00E04020; cyc();
    inst_in = '0; cyc();
    chk("byp_stored", rsd, 32'hDEADBEEF);
    inst_in = 32'h00004020; cyc();
    wb_we = 1; wb_rd = 0; wb_data = 32'h12345678; inst_in = '0; cyc();
    chk("r0_bypass", {rsd, rtd}, 0);
    wb_we = 0; inst_in = 32'h00004020; cyc();
    inst_in = '0; cyc();
    chk("r0_write", {rsd, rtd}, 0);

    // flush
    inst_in = BEQ; cyc();
    flush = 1; inst_in = ADDI; cyc();
    chk("fl_beq_issue", ctrl, 9'h005);
    flush = 0; inst_in = '0; cyc();
    chk("fl_bubble", {ctrl, rs, rt}, 0);
    inst_in = LW;  cyc();
    inst_in = ADD; cyc();
    flush = 1; inst_in = ADDI; cyc();
    chk("flh_cnt", scnt, 2);
    chk("flh_bubble", ctrl, 0);
    flush = 0; inst_in = '0; cyc();
    chk("flh_ifid_cleared", {ctrl, rs, rt, rd}, 0);

    // reset mid-stall
    inst_in = LW;  cyc();
    inst_in = ADD; cyc();
    chk("rst_pre_stall", pcw, 0);
    #2 rst = 1; m_reset();
    #1;
    chk("rst_ex", dut_ex, 0);
    chk("rst_cnt", scnt, 0);
    chk("rst_pcw", pcw, 1);
    @(negedge clk);
    rst = 0; inst_in = 32'h00A04020;
    cyc();
    inst_in = '0; cyc();
    chk("rst_r5", {ctrl, rs, rsd}, {9'h10A, 5'd5, 32'h0});

    // random traffic vs model
    for (int n = 0; n < 1500; n++) begin
      int k = $urandom_range(0, 6);
      logic [5:0] op = (k == 0) ? 6'h00 : (k <= 2) ? 6'h23 : (k == 3) ? 6'h2B :
                       (k == 4) ? 6'h04 : (k == 5) ? 6'h08 : 6'($urandom);
      inst_in = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 11'($urandom)};
      if ($urandom_range(0, 19) == 0) inst_in = '0;
      flush   = ($urandom_range(0, 7) == 0);
      wb_we   = 1'($urandom);
      wb_rd   = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      #1;
      chk("rnd_pcw", {s_pcw, pcw}, {2{!m_haz()}});
      cyc();
      chk("rnd_ex", dut_ex, m_ex);
      chk("rnd_sat_ex", sat_ex, m_ex);
      chk("rnd_cnt", {s_scnt, scnt}, {sat(m_cnt, 15), sat(m_cnt, 65535)});
    end

    // back-to-back dependent loads: a stall every other cycle
    flush = 0; wb_we = 0; inst_in = 32'h8C630000;
    for (int n = 0; n < 80; n++) begin
      cyc();
      chk("sat_run_cnt", {s_scnt, scnt}, {sat(m_cnt, 15), sat(m_cnt, 65535)});
      chk("sat_run_ex", dut_ex, m_ex);
    end
    chk("sat_hold", s_scnt, 16'h000F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
